csa_seq_mult: RTL and testbench

Parametrised, multi-cycle multiplier that succeeds the combinational carry-save array multiplier. It processes BITS_PER_CYCLE multiplier bits per clock into a carry-save accumulator. A single carry-propagate add then resolves the product. It adds a signed (two's complement) mode and a valid/ready handshake on both operand and result sides, so it can sit directly in the datapath between operand registers and the writeback stage.

---
 rtl/csa_seq_mult.sv | 141 ++++++++++++++
 tb/tb_csa_seq_mult.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_seq_mult.sv
// Sequential carry-save multiplier: BITS_PER_CYCLE partial products per cycle into a
// sum/carry pair, then a single carry-propagate add into the registered product.
//
// state   | meaning
// IDLE    | ready for operands; P holds the last product
// ACCUM   | compressing BITS_PER_CYCLE partial products per cycle, no carry propagation
// RESOLVE | sum + carry written into P
// DONE    | product offered on out_valid until out_ready
module csa_seq_mult #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     x_q;
    logic [WIDTH-1:0]  y_q;
    logic              sgn_q;
    logic [PW-1:0]     sum_q, carry_q;
    logic [PW-1:0]     sum_n, carry_n;
    logic [PW-1:0]     row, maj;
    logic              inj;
    logic              last_step;

    assign last_step = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_n = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (last_step)
                    state_n = RESOLVE;
            end
            RESOLVE: begin
                busy    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Chain of 3:2 compressors. x_q/y_q are pre-shifted each cycle, so row j here has
    // weight 2^(cnt*BPC+j). The negative MSB row uses the always-free carry bit 0 for its +1.
    always_comb begin
        sum_n   = sum_q;
        carry_n = carry_q;
        row     = '0;
        maj     = '0;
        inj     = 1'b0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            row = '0;
            inj = 1'b0;
            if (y_q[j]) begin
                if (sgn_q && last_step && (j == BITS_PER_CYCLE - 1)) begin
                    row = ~(x_q << j);
                    inj = 1'b1;
                end else begin
                    row = x_q << j;
                end
            end
            maj     = (sum_n & carry_n) | (sum_n & row) | (carry_n & row);
            sum_n   = sum_n ^ carry_n ^ row;
            carry_n = {maj[PW-2:0], inj};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            P       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= is_signed ? {{WIDTH{X[WIDTH-1]}}, X} : {{WIDTH{1'b0}}, X};
                        y_q     <= Y;
                        sgn_q   <= is_signed;
                        cnt     <= '0;
                        sum_q   <= '0;
                        carry_q <= '0;
                    end
                end
                ACCUM: begin
                    sum_q   <= sum_n;
                    carry_q <= carry_n;
                    x_q     <= x_q << BITS_PER_CYCLE;
                    y_q     <= y_q >> BITS_PER_CYCLE;
                    if (!last_step)
                        cnt <= cnt + CW'(1);
                end
                RESOLVE: P <= sum_q + carry_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_mult.sv
// Bench for csa_seq_mult: directed 16/1 instance plus a randomized parameter sweep,
// each with an expected-product queue drained by an independent output monitor.
module tb_csa_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic rst = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- directed instance, WIDTH=16, BITS_PER_CYCLE=1 ----------------
    logic        d_reset = 1'b1;
    logic        d_in_valid = 1'b0, d_in_ready, d_sig = 1'b0;
    logic [15:0] d_x = '0, d_y = '0;
    logic        d_out_valid, d_out_ready = 1'b0, d_busy;
    logic [31:0] d_p;
    logic [31:0] d_exp_q[$];
    int          d_acc_q[$];
    logic        d_have = 1'b0;

    csa_seq_mult #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dir (
        .clk(clk), .reset(d_reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .is_signed(d_sig), .X(d_x), .Y(d_y), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .P(d_p), .busy(d_busy)
    );

    always @(negedge clk) begin
        if (d_out_valid && !d_have) begin
            if (d_exp_q.size() == 0) begin
                chk("d_unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                logic [31:0] e;
                int a;
                e = d_exp_q.pop_front();
                a = d_acc_q.pop_front();
                chk("d_product", d_p, e);
                chk("d_latency", cyc - a, 17);
            end
            d_have = 1'b1;
        end else if (!d_out_valid) begin
            d_have = 1'b0;
        end
    end

    task automatic d_run(input logic [15:0] xv, input logic [15:0] yv, input logic s,
                         input logic [31:0] e, input int hold, input string nm);
        int k, nb;
        @(negedge clk);
        chk({nm, "_in_ready"}, d_in_ready, 1);
        d_x = xv; d_y = yv; d_sig = s; d_in_valid = 1'b1;
        d_out_ready = (hold == 0);
        d_exp_q.push_back(e);
        d_acc_q.push_back(cyc + 1);
        @(negedge clk);
        d_in_valid = 1'b0; d_x = ~xv; d_y = ~yv; d_sig = ~s;
        k = 0; nb = 0;
        while (!d_out_valid && k < 100) begin
            if (d_busy) nb++;
            @(negedge clk);
            k++;
        end
        chk({nm, "_busy_cycles"}, nb, 17);
        chk({nm, "_out_valid_seen"}, d_out_valid, 1);
        chk({nm, "_busy_in_done"}, d_busy, 0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                d_in_valid = i[0];
                @(negedge clk);
                chk({nm, "_hold_out_valid"}, d_out_valid, 1);
                chk({nm, "_hold_in_ready"}, d_in_ready, 0);
                chk({nm, "_hold_p"}, d_p, e);
            end
            d_in_valid = 1'b0;
            d_out_ready = 1'b1;
        end
        @(negedge clk);
        chk({nm, "_after_hs_out_valid"}, d_out_valid, 0);
        chk({nm, "_after_hs_in_ready"}, d_in_ready, 1);
        d_out_ready = 1'b0;
    endtask

    // ---------------- randomized sweep: WIDTH {8,16,32} x BPC {1,2,4} ----------------
    for (genvar g = 0; g < 9; g++) begin : sweep
        localparam int W = 8 << (g / 3);
        localparam int B = 1 << (g % 3);
        localparam int N = W / B;

        logic           in_valid = 1'b0, in_ready, is_signed = 1'b0;
        logic [W-1:0]   x = '0, y = '0;
        logic           out_valid, out_ready = 1'b0, busy;
        logic [2*W-1:0] p;
        logic [2*W-1:0] exp_q[$];
        int             acc_q[$];
        logic           have = 1'b0;
        logic [2*W-1:0] cur = '0;

        csa_seq_mult #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
            .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
            .is_signed(is_signed), .X(x), .Y(y), .out_valid(out_valid),
            .out_ready(out_ready), .P(p), .busy(busy)
        );

        initial begin
            logic [W-1:0]          xv, yv;
            logic signed [2*W-1:0] sa, sb;
            logic [2*W-1:0]        ua, ub, e;
            logic                  s;
            int                    k;
            @(negedge clk);
            while (rst) @(negedge clk);
            for (int op = 0; op < 2000; op++) begin
                k = 0;
                while (!in_ready && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                if (!in_ready) begin
                    chk($sformatf("sweep_w%0d_b%0d_in_ready_timeout", W, B), 0, 1);
                    break;
                end
                s  = (op >= 1000);
                xv = W'($urandom);
                yv = W'($urandom);
                if (op % 200 == 0) xv = {1'b1, {(W-1){1'b0}}};
                if (op % 300 == 0) yv = {1'b1, {(W-1){1'b0}}};
                if (s) begin
                    sa = $signed(xv);
                    sb = $signed(yv);
                    e  = sa * sb;
                end else begin
                    ua = {{W{1'b0}}, xv};
                    ub = {{W{1'b0}}, yv};
                    e  = ua * ub;
                end
                x = xv; y = yv; is_signed = s; in_valid = 1'b1;
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                @(negedge clk);
                in_valid = 1'b0; x = W'($urandom); y = W'($urandom); is_signed = ~s;
            end
            k = 0;
            while (exp_q.size() != 0 && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("sweep_w%0d_b%0d_drained", W, B), exp_q.size(), 0);
            done_cnt++;
        end

        always @(negedge clk) begin
            if (out_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("sweep_w%0d_b%0d_unexpected", W, B), 1, 0);
                    end else begin
                        int a;
                        cur = exp_q.pop_front();
                        a   = acc_q.pop_front();
                        chk($sformatf("sweep_w%0d_b%0d_product", W, B), p, cur);
                        chk($sformatf("sweep_w%0d_b%0d_latency", W, B), cyc - a, N + 1);
                    end
                    have = 1'b1;
                end else begin
                    chk($sformatf("sweep_w%0d_b%0d_stall_p", W, B), p, cur);
                end
                chk($sformatf("sweep_w%0d_b%0d_exclusive", W, B), in_ready, 0);
                out_ready = (($urandom % 8) != 0);
                if (out_ready) have = 1'b0;
            end else begin
                out_ready = $urandom_range(0, 1);
            end
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin
        int k;
        rst = 1'b1;
        d_reset = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", d_in_ready, 1);
        chk("reset_out_valid", d_out_valid, 0);
        chk("reset_busy", d_busy, 0);
        chk("reset_p", d_p, 0);
        d_reset = 1'b0;

        d_run(16'h1234, 16'h5678, 1'b0, 32'h06260060, 0, "u_1234x5678");
        d_run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, "u_ffffxffff");
        d_run(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0, "s_ffffxffff");
        d_run(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, "s_8000x8000");
        d_run(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0, "s_8000x0001");
        d_run(16'h0000, 16'h8000, 1'b1, 32'h00000000, 0, "s_0000x8000");
        d_run(16'h7FFF, 16'h8001, 1'b1, 32'hC000FFFF, 10, "bp_7fffx8001");

        // abort mid-ACCUM: after accept edge E and 8 more edges the step counter is 8
        @(negedge clk);
        d_x = 16'hABCD; d_y = 16'h1357; d_sig = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_before_reset", d_busy, 1);
        d_reset = 1'b1;
        @(negedge clk);
        d_reset = 1'b0;
        d_out_ready = 1'b0;
        chk("mid_reset_in_ready", d_in_ready, 1);
        chk("mid_reset_out_valid", d_out_valid, 0);
        chk("mid_reset_busy", d_busy, 0);
        chk("mid_reset_p", d_p, 0);
        d_run(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 0, "after_reset_3x5");

        k = 0;
        while (done_cnt < 9 && k < 90000) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_completion", done_cnt, 9);
        chk("directed_queue_empty", d_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
